// File: rtl/rv32_pkg.sv
// Shared constants for the pipeline hazard controller: opcodes, FSM states
// and operand-source encodings.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): decode/execute/memory status in, stall/flush/forward controls out.
interface pipe_ctrl_if;
  logic [31:0] dec_ins;
  logic        dec_valid;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_is_load;
  logic [4:0]  mem_rd;
  logic        mem_wen;
  logic        mem_busy;
  logic        br_taken;
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        idex_bubble;
  logic        ifid_flush;
  logic [1:0]  fwd_sel1;
  logic [1:0]  fwd_sel2;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles;

  modport master (
    output dec_ins, dec_valid, ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen,
           mem_busy, br_taken,
    input  pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush,
           fwd_sel1, fwd_sel2, ctrl_state, stall_cycles
  );

  modport slave (
    input  dec_ins, dec_valid, ex_rd, ex_wen, ex_is_load, mem_rd, mem_wen,
           mem_busy, br_taken,
    output pc_stall, ifid_stall, idex_stall, idex_bubble, ifid_flush,
           fwd_sel1, fwd_sel2, ctrl_state, stall_cycles
  );
endinterface

// File: rtl/pipe_fwd_sel.sv
// Operand-source selection for one decode-stage source register; x0 never
// matches a producer.
module pipe_fwd_sel
  import rv32_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic       src_used,
  input  logic       dec_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_wen,
  input  logic       lu_stall,
  output logic       ex_match,
  output logic [1:0] fwd_sel
);

  logic mem_match;

  // A load caught in EX during the bubble cycle has reached MEM by the time
  // its data is consumed, so it is sourced from the MEM result.
  always_comb begin
    ex_match  = dec_valid && src_used && ex_wen && (ex_rd != 5'd0) && (ex_rd == src_reg);
    mem_match = dec_valid && src_used && mem_wen && (mem_rd != 5'd0) && (mem_rd == src_reg);
    fwd_sel   = FWD_RF;
    if (ex_match && !ex_is_load) begin
      fwd_sel = FWD_EX;
    end else if (mem_match || (ex_match && lu_stall)) begin
      fwd_sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze, branch
// flush, operand forwarding and a saturating stall-cycle counter.
module pipe_ctrl
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  ctrl_state_e state;
  ctrl_state_e next_state;
  logic [15:0] stall_cnt;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic        ex_match1;
  logic        ex_match2;
  logic [1:0]  sel1;
  logic [1:0]  sel2;
  logic        lu_hazard;
  logic        lu_stall;

  assign opcode   = bus.dec_ins[6:0];
  assign rs1      = bus.dec_ins[19:15];
  assign rs2      = bus.dec_ins[24:20];
  assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign rs2_used = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign lu_stall = (state == ST_LU_STALL);

  pipe_fwd_sel u_fwd_rs1 (
    .src_reg    (rs1),
    .src_used   (rs1_used),
    .dec_valid  (bus.dec_valid),
    .ex_rd      (bus.ex_rd),
    .ex_wen     (bus.ex_wen),
    .ex_is_load (bus.ex_is_load),
    .mem_rd     (bus.mem_rd),
    .mem_wen    (bus.mem_wen),
    .lu_stall   (lu_stall),
    .ex_match   (ex_match1),
    .fwd_sel    (sel1)
  );

  pipe_fwd_sel u_fwd_rs2 (
    .src_reg    (rs2),
    .src_used   (rs2_used),
    .dec_valid  (bus.dec_valid),
    .ex_rd      (bus.ex_rd),
    .ex_wen     (bus.ex_wen),
    .ex_is_load (bus.ex_is_load),
    .mem_rd     (bus.mem_rd),
    .mem_wen    (bus.mem_wen),
    .lu_stall   (lu_stall),
    .ex_match   (ex_match2),
    .fwd_sel    (sel2)
  );

  assign lu_hazard = (ex_match1 || ex_match2) && bus.ex_is_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // A frozen memory access outranks a redirect, which outranks a load-use stall.
  always_comb begin
    next_state = ST_RUN;
    if (bus.mem_busy) begin
      next_state = ST_MEM_WAIT;
    end else if (bus.br_taken) begin
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN:      next_state = lu_hazard ? ST_LU_STALL : ST_RUN;
        ST_LU_STALL: next_state = ST_RUN;
        ST_MEM_WAIT: next_state = ST_RUN;
        default:     next_state = ST_RUN;
      endcase
    end
  end

  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.ifid_stall  = 1'b0;
    bus.idex_stall  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.fwd_sel1    = FWD_RF;
    bus.fwd_sel2    = FWD_RF;
    if (!rst) begin
      bus.fwd_sel1 = sel1;
      bus.fwd_sel2 = sel2;
      if (bus.mem_busy) begin
        bus.pc_stall   = 1'b1;
        bus.ifid_stall = 1'b1;
        bus.idex_stall = 1'b1;
      end else if (bus.br_taken) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_bubble = 1'b1;
      end else if ((state == ST_RUN) && lu_hazard) begin
        bus.pc_stall    = 1'b1;
        bus.ifid_stall  = 1'b1;
        bus.idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if (bus.pc_stall && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.ctrl_state   = state;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- dec_ins  in  32  instruction held in the decode stage
- dec_valid  in  1  decode stage holds a real instruction
- ex_rd  in  5  destination register of the instruction in execute
- ex_wen  in  1  execute instruction writes a register
- ex_is_load  in  1  execute instruction is a memory load
- mem_rd  in  5  destination register of the instruction in memory stage
- mem_wen  in  1  memory-stage instruction writes a register
- mem_busy  in  1  data memory access not complete; pipeline must freeze
- br_taken  in  1  execute resolved a taken branch or jump (redirect)
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- idex_stall  out  1  hold ID/EX register
- idex_bubble  out  1  load a NOP into ID/EX
- ifid_flush  out  1  load a NOP into IF/ID
- fwd_sel1, fwd_sel2  out  2 each  operand source: 0 register file, 1 EX result, 2 MEM result
- ctrl_state  out  2  current FSM state (debug)
- stall_cycles  out  16  count of cycles with pc_stall=1

Function
REQ-003 rs1=dec_ins[19:15], rs2=dec_ins[24:20], opcode=dec_ins[6:0].
REQ-004 rs1 SHALL be treated as used for all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
REQ-005 rs2 SHALL be treated as used only for opcodes 0110011, 0100011 and 1100011.
REQ-006 A register match SHALL require dec_valid=1, a used source, a write-enabled producer, and a producer rd != 0; x0 SHALL never be forwarded or stalled on.
REQ-007 fwd_selN SHALL be 1 on an EX match with ex_is_load=0, else 2 on a MEM match, else 0; an EX match SHALL take priority over a MEM match.
REQ-008 The FSM states SHALL be RUN(0), LU_STALL(1) and MEM_WAIT(2); value 3 is unused and SHALL recover to RUN on the next cycle.
REQ-009 Transitions SHALL be evaluated in this priority order: mem_busy=1 -> MEM_WAIT; else br_taken=1 -> RUN; else load-use hazard in RUN -> LU_STALL; LU_STALL -> RUN unconditionally; MEM_WAIT -> RUN when mem_busy=0.
REQ-010 A load-use hazard SHALL be an EX match (REQ-006) with ex_is_load=1.
REQ-011 In RUN with a load-use hazard (no mem_busy, no br_taken), the same cycle SHALL drive pc_stall=1, ifid_stall=1, idex_bubble=1; exactly one bubble cycle SHALL be inserted.
REQ-012 In LU_STALL, no stall SHALL be asserted and the dependent operand SHALL select 2 (MEM).
REQ-013 While mem_busy=1 (in any state), pc_stall, ifid_stall and idex_stall SHALL be 1 and idex_bubble and ifid_flush SHALL be 0.
REQ-014 br_taken=1 with mem_busy=0 SHALL drive ifid_flush=1 and idex_bubble=1 in the same cycle and suppress any load-use stall.
REQ-015 br_taken asserted during MEM_WAIT SHALL be held stable by execute and SHALL be applied on the first cycle in which mem_busy=0.
REQ-016 Stall and flush outputs SHALL be combinational from the state and inputs; ctrl_state and stall_cycles SHALL be registered.
REQ-017 stall_cycles SHALL increment on each cycle with pc_stall=1 and saturate at 16'hFFFF.

Reset
REQ-018 On a clock edge with rst=1, state SHALL go to RUN and stall_cycles SHALL go to 0.
REQ-019 While rst=1, all stall, flush and bubble outputs SHALL be 0 and fwd_sel1/fwd_sel2 SHALL be 0.
REQ-020 Reset asserted during LU_STALL or MEM_WAIT SHALL abandon that state with no pending redirect retained.

Structure
REQ-021 The opcode constants, FSM state encodings and fwd_sel encodings SHALL live in the shared package rv32_pkg.
REQ-022 Operand-source selection SHALL be a sub-module pipe_fwd_sel (one source register in, match and select out), instantiated once for rs1 and once for rs2.

Verification
REQ-023 ex: lw x5 (ex_is_load=1, ex_rd=5); dec: add x6,x5,x7 -> one cycle with pc_stall=ifid_stall=idex_bubble=1, then LU_STALL with fwd_sel1=2, then RUN.
REQ-024 ex_rd=3, ex_wen=1, ex_is_load=0; mem_rd=3, mem_wen=1; dec: sub x1,x3,x3 -> fwd_sel1=fwd_sel2=1 and no stall.
REQ-025 ex_rd=0 with ex_wen=1, ex_is_load=1; dec: add x1,x0,x0 -> no stall and fwd_sel=0.
REQ-026 mem_busy=1 for 3 cycles with br_taken=1 held -> 3 frozen cycles (stall_cycles +3), then one cycle with ifid_flush=idex_bubble=1.
REQ-027 Load-use hazard and br_taken in the same cycle -> flush only, pc_stall=0, state stays RUN.
REQ-028 stall_cycles preloaded near 16'hFFFF by a long mem_busy -> stays at 16'hFFFF; rst pulse mid-MEM_WAIT -> state RUN and counter 0 on the next edge.
